// File: rtl/seg_capture.sv
// Captures a multiplexed, active-low 8-digit 7-segment display back into a
// 32-bit hex value, with per-digit glyph error flags, frame pulse and staleness.
module seg_capture #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  an,
    input  logic [6:0]  yn,
    output logic [31:0] value,
    output logic [7:0]  err,
    output logic        frame_valid,
    output logic        stale
);
    localparam int unsigned   TW      = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    CAP_CNT = 8'(SETTLE - 1);
    localparam logic [7:0]    SAT_CNT = 8'(SETTLE);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);

    logic [7:0]    an_s1_q, an_s1_d, an_s2_q, an_s2_d;
    logic [6:0]    yn_s1_q, yn_s1_d, yn_s2_q, yn_s2_d;
    logic [14:0]   prev_q, prev_d, cur;
    logic [7:0]    cnt_q, cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [31:0]   value_q, value_d;
    logic [7:0]    err_q, err_d;
    logic [7:0]    seen_q, seen_d, seen_next;
    logic          fv_q, fv_d;
    logic          stale_q, stale_d;
    logic          changed, capture, valid;
    logic [4:0]    glyph;

    // Returns {legal, nibble} for an active-low segment pattern (a..g).
    function automatic logic [4:0] decode(input logic [6:0] g);
        case (g)
            7'h01:   decode = {1'b1, 4'h0};
            7'h4F:   decode = {1'b1, 4'h1};
            7'h12:   decode = {1'b1, 4'h2};
            7'h06:   decode = {1'b1, 4'h3};
            7'h4C:   decode = {1'b1, 4'h4};
            7'h24:   decode = {1'b1, 4'h5};
            7'h20:   decode = {1'b1, 4'h6};
            7'h0F:   decode = {1'b1, 4'h7};
            7'h00:   decode = {1'b1, 4'h8};
            7'h04:   decode = {1'b1, 4'h9};
            7'h08:   decode = {1'b1, 4'hA};
            7'h60:   decode = {1'b1, 4'hB};
            7'h31:   decode = {1'b1, 4'hC};
            7'h42:   decode = {1'b1, 4'hD};
            7'h30:   decode = {1'b1, 4'hE};
            7'h38:   decode = {1'b1, 4'hF};
            default: decode = {1'b0, 4'h0};
        endcase
    endfunction

    always_comb begin
        an_s1_d = an;
        yn_s1_d = yn;
        an_s2_d = an_s1_q;
        yn_s2_d = yn_s1_q;
        cur     = {an_s2_q, yn_s2_q};
        prev_d  = cur;
        changed = (cur != prev_q);

        if (changed)
            cnt_d = '0;
        else if (cnt_q != SAT_CNT)
            cnt_d = cnt_q + 8'd1;
        else
            cnt_d = cnt_q;

        // Counter saturates above CAP_CNT, so this fires once per stable interval.
        capture = !changed && (cnt_d == CAP_CNT);
        valid   = capture && $onehot(~an_s2_q);
        glyph   = decode(yn_s2_q);

        value_d   = value_q;
        err_d     = err_q;
        seen_d    = seen_q;
        seen_next = seen_q | ~an_s2_q;
        fv_d      = 1'b0;
        if (valid) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (!an_s2_q[i[2:0]]) begin
                    if (glyph[4]) begin
                        value_d[{i[2:0], 2'b00} +: 4] = glyph[3:0];
                        err_d[i[2:0]] = 1'b0;
                    end else begin
                        err_d[i[2:0]] = 1'b1;
                    end
                end
            end
            if (&seen_next) begin
                fv_d   = 1'b1;
                seen_d = '0;
            end else begin
                seen_d = seen_next;
            end
        end

        if (valid)
            tcnt_d = '0;
        else if (tcnt_q != TO_MAX)
            tcnt_d = tcnt_q + 1'b1;
        else
            tcnt_d = tcnt_q;
        stale_d = (tcnt_d == TO_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_s1_q <= '1;
            an_s2_q <= '1;
            yn_s1_q <= '1;
            yn_s2_q <= '1;
            prev_q  <= '1;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            value_q <= '0;
            err_q   <= '0;
            seen_q  <= '0;
            fv_q    <= 1'b0;
            stale_q <= 1'b0;
        end else begin
            an_s1_q <= an_s1_d;
            an_s2_q <= an_s2_d;
            yn_s1_q <= yn_s1_d;
            yn_s2_q <= yn_s2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            value_q <= value_d;
            err_q   <= err_d;
            seen_q  <= seen_d;
            fv_q    <= fv_d;
            stale_q <= stale_d;
        end
    end

    assign value       = value_q;
    assign err         = err_q;
    assign frame_valid = fv_q;
    assign stale       = stale_q;

endmodule
